// File: rtl/dmem_lsu.sv
// Load/store unit driving the riscv32i dmem port: big-endian, whole-word writes, RMW for sub-word stores.
// Optional misalignment detection is enabled by defining LSU_MISALIGN_CHECK_EN.
module dmem_lsu #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [1:0]    req_size,
  input  logic          req_unsigned,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic          mem_r_w,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_data,
  input  logic [DW-1:0] mem_out
);

  typedef enum logic [2:0] {IDLE, ACCESS, CAPTURE, WRITE, RESP} state_e;

  state_e        state_q, state_d;
  logic          we_q, we_d;
  logic [1:0]    size_q, size_d;
  logic          uns_q, uns_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] word_q, word_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          err_q, err_d;

  logic          misaligned;
  logic          is_word;
  logic          word_store;
  logic [7:0]    byte_v;
  logic [15:0]   half_v;
  logic [DW-1:0] loaded;
  logic [DW-1:0] merged;

`ifdef LSU_MISALIGN_CHECK_EN
  assign misaligned = ((req_size == 2'b01) && req_addr[0]) ||
                      (req_size[1] && (req_addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  // Size 2'b11 falls into the word case because only bit 1 is looked at.
  assign is_word    = size_q[1];
  assign word_store = we_q && is_word;

  // Lane extraction and merge; byte offset 0 is the most significant lane.
  always_comb begin
    byte_v = mem_out[31:24];
    unique case (addr_q[1:0])
      2'd0: byte_v = mem_out[31:24];
      2'd1: byte_v = mem_out[23:16];
      2'd2: byte_v = mem_out[15:8];
      2'd3: byte_v = mem_out[7:0];
    endcase
    half_v = addr_q[1] ? mem_out[15:0] : mem_out[31:16];

    if (is_word)        loaded = mem_out;
    else if (size_q[0]) loaded = {{16{half_v[15] & ~uns_q}}, half_v};
    else                loaded = {{24{byte_v[7] & ~uns_q}}, byte_v};

    merged = mem_out;
    if (size_q[0]) begin
      if (addr_q[1]) merged[15:0]  = wdata_q[15:0];
      else           merged[31:16] = wdata_q[15:0];
    end else begin
      unique case (addr_q[1:0])
        2'd0: merged[31:24] = wdata_q[7:0];
        2'd1: merged[23:16] = wdata_q[7:0];
        2'd2: merged[15:8]  = wdata_q[7:0];
        2'd3: merged[7:0]   = wdata_q[7:0];
      endcase
    end
  end

  always_comb begin
    // NOTE: every _d gets its hold value first, so no path can infer a latch.
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    word_d  = word_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          size_d  = req_size;
          uns_d   = req_unsigned;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          rdata_d = '0;
          err_d   = misaligned;
          state_d = misaligned ? RESP : ACCESS;
        end
      end
      ACCESS:  state_d = word_store ? RESP : CAPTURE;
      CAPTURE: begin
        if (we_q) begin
          word_d  = merged;
          state_d = WRITE;
        end else begin
          rdata_d = loaded;
          state_d = RESP;
        end
      end
      WRITE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      word_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every flop samples pre-edge values.
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      word_q  <= word_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Decoded from state so an asynchronous reset drops the write strobe at once.
  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = rsp_valid && err_q;
  assign mem_r_w   = ((state_q == ACCESS) && word_store) || (state_q == WRITE);
  assign mem_addr  = {addr_q[AW-1:2], 2'b00};
  assign mem_data  = (state_q == WRITE) ? word_q :
                     ((state_q == ACCESS) && word_store) ? wdata_q : '0;

endmodule

// File: tb/tb_dmem_lsu.sv
// Randomized bench for dmem_lsu: byte-array reference model of big-endian memory plus directed plan items.
// Honours LSU_MISALIGN_CHECK_EN the same way the design does.
module tb_dmem_lsu;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [1:0]    req_size = 2'b00;
  logic          req_unsigned = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          mem_r_w;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic [DW-1:0] mem_out = '0;

  dmem_lsu #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .mem_r_w(mem_r_w), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_out(mem_out)
  );

  always #5 clk = ~clk;

  // dmem: synchronous word memory, read data one cycle after the address.
  logic [31:0] mem     [0:63];
  logic [31:0] ref_mem [0:63];
  always @(posedge clk) begin
    if (mem_r_w) mem[mem_addr[7:2]] <= mem_data;
    mem_out <= mem[mem_addr[7:2]];
  end

  int n_cmp = 0;
  int n_err = 0;
  int op_idx = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s (op %0d): got 0x%08h expected 0x%08h", tag, op_idx, got, exp);
    end
  endtask

  function automatic logic ref_misaligned(input logic [1:0] size, input int a);
`ifdef LSU_MISALIGN_CHECK_EN
    return (size == 2'b01 && (a % 2) != 0) || (size >= 2'b10 && (a % 4) != 0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] size,
                                           input logic uns, input int a);
    int b [4];
    int v;
    for (int i = 0; i < 4; i++) b[i] = (w >> (8 * (3 - i))) & 255;
    if (size >= 2'b10) return w;
    if (size == 2'b01) begin
      v = b[a & 2] * 256 + b[(a & 2) + 1];
      if (!uns && v >= 32768) v = v - 65536;
    end else begin
      v = b[a % 4];
      if (!uns && v >= 128) v = v - 256;
    end
    return 32'(v);
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] w, input logic [1:0] size,
                                            input logic [31:0] wd, input int a);
    int b [4];
    if (size >= 2'b10) return wd;
    for (int i = 0; i < 4; i++) b[i] = (w >> (8 * (3 - i))) & 255;
    if (size == 2'b01) begin
      b[a & 2]       = (wd >> 8) & 255;
      b[(a & 2) + 1] = wd & 255;
    end else begin
      b[a % 4] = wd & 255;
    end
    return 32'(b[0] * 16777216 + b[1] * 65536 + b[2] * 256 + b[3]);
  endfunction

  // Observations from the last request.
  int          o_lat, o_nwr, o_wcyc;
  logic [31:0] o_rdata, o_waddr, o_wdata, o_raddr;
  logic        o_err, o_busy_ready;

  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd);
    o_lat = 0; o_nwr = 0; o_wcyc = 0; o_rdata = '0; o_err = 1'b0;
    o_waddr = '0; o_wdata = '0; o_raddr = '0; o_busy_ready = 1'b0;
    issue(we, size, uns, addr, wd);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (req_ready) o_busy_ready = 1'b1;
      if (k == 1) o_raddr = mem_addr;
      if (mem_r_w) begin
        o_nwr++; o_wcyc = k; o_waddr = mem_addr; o_wdata = mem_data;
      end
      if (rsp_valid) begin
        o_lat = k; o_rdata = rsp_rdata; o_err = rsp_err;
        break;
      end
    end
  endtask

  task automatic run_op(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd);
    int          a;
    logic        mis;
    int          exp_lat;
    logic [31:0] old_w, new_w;
    a = int'(addr);
    mis = ref_misaligned(size, a);
    old_w = ref_mem[a / 4];
    op_idx++;
    do_req(we, size, uns, addr, wd);
    if (mis)                     exp_lat = 1;
    else if (!we)                exp_lat = 3;
    else if (size >= 2'b10)      exp_lat = 2;
    else                         exp_lat = 4;
    check("latency", 32'(o_lat), 32'(exp_lat));
    check("rsp_err", {31'b0, o_err}, {31'b0, mis});
    check("rsp_rdata", o_rdata, (mis || we) ? 32'h0 : ref_load(old_w, size, uns, a));
    check("write_count", 32'(o_nwr), (!mis && we) ? 32'd1 : 32'd0);
    check("ready_low_busy", {31'b0, o_busy_ready}, 32'd0);
    if (!mis) check("rd_addr", o_raddr, addr & 32'hFFFF_FFFC);
    if (!mis && we) begin
      new_w = ref_store(old_w, size, wd, a);
      ref_mem[a / 4] = new_w;
      check("write_cycle", 32'(o_wcyc), (size >= 2'b10) ? 32'd1 : 32'd3);
      check("write_addr", o_waddr, addr & 32'hFFFF_FFFC);
      check("write_data", o_wdata, new_w);
    end
    @(negedge clk);
    check("rsp_one_cycle", {31'b0, rsp_valid}, 32'd0);
    check("ready_after", {31'b0, req_ready}, 32'd1);
    check("mem_word", mem[a / 4], ref_mem[a / 4]);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[4] = 32'h1122_3344; ref_mem[4] = 32'h1122_3344;
    mem[8] = 32'h80A0_B0C0; ref_mem[8] = 32'h80A0_B0C0;

    #2;
    check("rst_ready", {31'b0, req_ready}, 32'd1);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
    check("rst_mem_r_w", {31'b0, mem_r_w}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_data", mem_data, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed plan items with literal expectations.
    run_op(1'b0, 2'b00, 1'b0, 32'h11, 32'h0);
    check("plan_lb_11", o_rdata, 32'h0000_0022);
    check("plan_lb_11_lat", 32'(o_lat), 32'd3);
    run_op(1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
    check("plan_lh_12", o_rdata, 32'h0000_3344);
    run_op(1'b0, 2'b00, 1'b0, 32'h21, 32'h0);
    check("plan_lb_21", o_rdata, 32'hFFFF_FFA0);
    run_op(1'b0, 2'b00, 1'b1, 32'h21, 32'h0);
    check("plan_lbu_21", o_rdata, 32'h0000_00A0);
    run_op(1'b0, 2'b01, 1'b0, 32'h20, 32'h0);
    check("plan_lh_20", o_rdata, 32'hFFFF_80A0);
    run_op(1'b1, 2'b00, 1'b0, 32'h12, 32'h0000_00EE);
    check("plan_sb_wdata", o_wdata, 32'h1122_EE44);
    check("plan_sb_wcyc", 32'(o_wcyc), 32'd3);
    check("plan_sb_lat", 32'(o_lat), 32'd4);
    run_op(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    check("plan_sb_readback", o_rdata, 32'h1122_EE44);
    run_op(1'b1, 2'b10, 1'b0, 32'h30, 32'hDEAD_BEEF);
    check("plan_sw_addr", o_waddr, 32'h30);
    check("plan_sw_wcyc", 32'(o_wcyc), 32'd1);
    check("plan_sw_lat", 32'(o_lat), 32'd2);
    run_op(1'b0, 2'b01, 1'b1, 32'h11, 32'h0);
`ifdef LSU_MISALIGN_CHECK_EN
    check("plan_mis_err", {31'b0, o_err}, 32'd1);
    check("plan_mis_lat", 32'(o_lat), 32'd1);
`else
    check("plan_mis_data", o_rdata, 32'h0000_1122);
`endif

    // Restore 0x10 then abort a byte store in cycle 2.
    run_op(1'b1, 2'b10, 1'b0, 32'h10, 32'h1122_3344);
    op_idx++;
    issue(1'b1, 2'b00, 1'b0, 32'h12, 32'h0000_00EE);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1 check("abort_mem_r_w", {31'b0, mem_r_w}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    o_lat = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (rsp_valid) o_lat = 1;
    end
    check("abort_no_rsp", 32'(o_lat), 32'd0);
    check("abort_ready", {31'b0, req_ready}, 32'd1);
    check("abort_mem_word", mem[4], 32'h1122_3344);

    // Abort a word store while its write strobe is high: strobe drops without a clock.
    op_idx++;
    issue(1'b1, 2'b10, 1'b0, 32'h30, 32'h0BAD_F00D);
    @(negedge clk);
    check("abort_sw_strobe", {31'b0, mem_r_w}, 32'd1);
    rst_n = 1'b0;
    #1 check("abort_sw_drop", {31'b0, mem_r_w}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_sw_word", mem[12], ref_mem[12]);

    for (int n = 0; n < 200; n++) begin
      run_op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             32'($urandom_range(0, 255)), $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
Load/store initiator for the riscv32i core's data memory port. It sits between the execute stage and dmem.
It accepts one byte, halfword or word load/store at a time and drives the dmem r_w/addr/data interface. Data is big-endian.
dmem writes whole words only, so sub-word stores are done as read-modify-write. Load data is aligned and sign- or zero-extended before return.

Parameters:
AW, 32, request and memory address width
DW, 32, data width (only 32 supported)

Ports:
clk  input  1  core clock; all state updates on rising edge
rst_n  input  1  reset; asynchronous, active-low
req_valid  input  1  core presents a request
req_ready  output  1  LSU can accept; high only in IDLE
req_we  input  1  1=store, 0=load
req_size  input  2  00 byte, 01 halfword, 10 word; 11 treated as word
req_unsigned  input  1  loads: 1=zero-extend, 0=sign-extend
req_addr  input  AW  byte address
req_wdata  input  DW  store data, right-justified
rsp_valid  output  1  one-cycle completion pulse
rsp_rdata  output  DW  load result; 0 for stores
rsp_err  output  1  misaligned request, qualified by rsp_valid
mem_r_w  output  1  to dmem r_w; 1=write
mem_addr  output  AW  to dmem mem_addr; always {req_addr[AW-1:2],2'b00}
mem_data  output  DW  to dmem mem_data
mem_out  input  DW  from dmem; valid the cycle after the address is presented with mem_r_w=0

Behaviour:
- Reset values: state=IDLE; req_ready=1; rsp_valid=0; rsp_rdata=0; rsp_err=0; mem_r_w=0; mem_addr=0; mem_data=0.
- Accept: when req_valid && req_ready, register we/size/unsigned/addr/wdata. The request-accept cycle is cycle 0.
- States: IDLE, ACCESS, CAPTURE, WRITE, RESP.
- IDLE -> ACCESS on accept. IDLE -> RESP directly if the request is misaligned.
- ACCESS (cycle 1): drive mem_addr.
  - Word store: mem_r_w=1, mem_data=wdata, then go to RESP.
  - Load or sub-word store: mem_r_w=0, then go to CAPTURE.
- CAPTURE (cycle 2): sample mem_out.
  - Load: extract and extend into rsp_rdata, then go to RESP.
  - Sub-word store: merge into a word register, then go to WRITE.
- WRITE (cycle 3): mem_r_w=1, mem_data=merged word, then go to RESP.
- RESP: rsp_valid=1 for exactly one cycle, then go to IDLE. There is no response backpressure.
- Latency (rsp_valid cycle): word store 2; load 3; byte/half store 4; misaligned 1.
- Big-endian lanes:
  - Byte offset 0 is mem_out[31:24], offset 3 is [7:0].
  - Halfword offset 0 is [31:16], offset 2 is [15:0].
- Sign extension uses the MSB of the extracted byte or halfword. Word loads pass through unchanged.
- Sub-word merge replaces only the addressed lane with wdata[7:0] or wdata[15:0]. All other lanes keep the read value.
- mem_r_w is high only in ACCESS (word store) or WRITE. A request produces exactly one write cycle.
- mem_addr holds its last value in IDLE.
- Misalignment: halfword with addr[0]=1, or word with addr[1:0]!=0. Response: rsp_err=1, rsp_rdata=0, no memory access.
- Reset mid-operation: the FSM returns to IDLE and mem_r_w drops immediately (asynchronously). An interrupted RMW leaves the memory word unchanged unless the WRITE edge has already occurred. No response is issued for the aborted request.
- req_valid held high while req_ready=0 is ignored. The core must hold the request until it is accepted.

Optional Feature:
Macro LSU_MISALIGN_CHECK_EN.
- Defined: misaligned requests are detected and reported with rsp_err as above.
- Undefined: no check is performed and rsp_err is tied to 0.
  - Halfword uses addr[1] only; addr[0] is ignored.
  - Word ignores addr[1:0].
  - Every request follows the normal access path.

Test Plan:
- Preload word 0x10=0x11223344. Load byte signed at 0x11 -> rsp_rdata=0x00000022, rsp_valid at cycle 3. Load halfword at 0x12 -> 0x00003344.
- Preload 0x20=0x80A0B0C0.
  - Signed byte at 0x21 -> 0xFFFFFFA0.
  - Unsigned byte at 0x21 -> 0x000000A0.
  - Signed halfword at 0x20 -> 0xFFFF80A0.
- Store byte wdata=0x000000EE at 0x12 over 0x11223344:
  - One read in cycle 1, then mem_r_w=1 in cycle 3 only, with mem_data=0x1122EE44.
  - rsp_valid at cycle 4; readback gives 0x1122EE44.
- Store word 0xDEADBEEF at 0x30: mem_r_w=1 only in cycle 1 with mem_addr=0x30, rsp_valid at cycle 2, req_ready low in cycles 1-2.
- With LSU_MISALIGN_CHECK_EN: halfword load at 0x11 -> rsp_valid and rsp_err=1 in cycle 1, mem_r_w never high. Without the macro: the same request returns the halfword at 0x10.
- Start a byte store at 0x12, then assert rst_n=0 in cycle 2:
  - mem_r_w=0 immediately, req_ready=1 after release, no rsp_valid.
  - Word 0x10 still reads 0x11223344.
